alu_logic_issuer: RTL and testbench

- Initiator/driver for the 32-bit combinational bitwise logic array in the ALU datapath.
- Accepts operand requests over a valid/ready handshake and registers the operands onto the array's a/b inputs.
- Waits a fixed settle interval, then samples the array's s output into a held response with a zero flag, presented over a valid/ready handshake.
- Sits between the ALU control/issue stage and the logic array; turns the combinational block into a handshaked, multi-cycle-safe unit.

---
 rtl/alu_logic_issuer.sv | 114 +++++++++++
 tb/tb_alu_logic_issuer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_issuer.sv
// Handshaked driver for the combinational bitwise logic array: registers operands onto the array,
// waits SETTLE_CYCLES, then captures s into a held response. Optional parity output: ALU_LOGIC_PARITY_EN.
module alu_logic_issuer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] arr_a,
  output logic [WIDTH-1:0] arr_b,
  input  logic [WIDTH-1:0] arr_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
`ifdef ALU_LOGIC_PARITY_EN
  output logic             rsp_parity,
`endif
  output logic [CNT_W-1:0] txn_count
);

  localparam int SC_W = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [SC_W-1:0]   cnt_q;
  logic [WIDTH-1:0]  arr_a_q;
  logic [WIDTH-1:0]  arr_b_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              rsp_zero_q;
  logic [CNT_W-1:0]  txn_q;
  logic [CNT_W-1:0]  txn_d;
`ifdef ALU_LOGIC_PARITY_EN
  logic              rsp_parity_q;
`endif

  assign txn_d = txn_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      cnt_q        <= '0;
      arr_a_q      <= '0;
      arr_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      txn_q        <= '0;
`ifdef ALU_LOGIC_PARITY_EN
      rsp_parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            arr_a_q     <= req_a;
            arr_b_q     <= req_b;
            cnt_q       <= SC_W'(SETTLE_CYCLES);
            req_ready_q <= 1'b0;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          // The array output is only trusted on the final settle edge.
          if (cnt_q == SC_W'(1)) begin
            rsp_data_q   <= arr_s;
            rsp_zero_q   <= (arr_s == '0);
`ifdef ALU_LOGIC_PARITY_EN
            rsp_parity_q <= ^arr_s;
`endif
            rsp_valid_q  <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - SC_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            txn_q       <= txn_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign arr_a      = arr_a_q;
  assign arr_b      = arr_b_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign txn_count  = txn_q;
`ifdef ALU_LOGIC_PARITY_EN
  assign rsp_parity = rsp_parity_q;
`endif

endmodule

// File: tb/tb_alu_logic_issuer.sv
// Directed bench for alu_logic_issuer: default instance (SETTLE=1) plus a SETTLE=3 / CNT_W=4 instance.
module tb_alu_logic_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters, array modelled as AND.
  logic        a_rst_n, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_zero;
  logic [31:0] a_req_a, a_req_b, a_arr_a, a_arr_b, a_arr_s, a_rsp_data;
  logic [15:0] a_txn;
`ifdef ALU_LOGIC_PARITY_EN
  logic        a_rsp_parity;
`endif
  assign a_arr_s = a_arr_a & a_arr_b;

  alu_logic_issuer u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_a(a_req_a), .req_b(a_req_b), .arr_a(a_arr_a), .arr_b(a_arr_b), .arr_s(a_arr_s),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_zero(a_rsp_zero),
`ifdef ALU_LOGIC_PARITY_EN
    .rsp_parity(a_rsp_parity),
`endif
    .txn_count(a_txn)
  );

  // Instance B: three settle cycles, 4-bit counter, array output can be overridden.
  logic        b_rst_n, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_zero;
  logic [31:0] b_req_a, b_req_b, b_arr_a, b_arr_b, b_arr_s, b_rsp_data;
  logic [3:0]  b_txn;
  logic        b_ovr;
  logic [31:0] b_ovr_val;
`ifdef ALU_LOGIC_PARITY_EN
  logic        b_rsp_parity;
`endif
  assign b_arr_s = b_ovr ? b_ovr_val : (b_arr_a & b_arr_b);

  alu_logic_issuer #(.WIDTH(32), .SETTLE_CYCLES(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .arr_a(b_arr_a), .arr_b(b_arr_b), .arr_s(b_arr_s),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_zero(b_rsp_zero),
`ifdef ALU_LOGIC_PARITY_EN
    .rsp_parity(b_rsp_parity),
`endif
    .txn_count(b_txn)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_req_valid = 1'b0; a_rsp_ready = 1'b0; a_req_a = '0; a_req_b = '0;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_rsp_ready = 1'b0; b_req_a = '0; b_req_b = '0;
    b_ovr = 1'b0; b_ovr_val = '0;
    tick();
    tick();
    chk("rst_arr_a", a_arr_a, 32'h0);
    chk("rst_arr_b", a_arr_b, 32'h0);
    chk("rst_rsp_data", a_rsp_data, 32'h0);
    chk("rst_rsp_zero", {31'b0, a_rsp_zero}, 32'h0);
    chk("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'h0);
    chk("rst_txn", {16'b0, a_txn}, 32'h0);
`ifdef ALU_LOGIC_PARITY_EN
    chk("rst_parity", {31'b0, a_rsp_parity}, 32'h0);
`endif
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();
    chk("idle_req_ready", {31'b0, a_req_ready}, 32'h1);

    // Single AND transaction.
    a_req_a = 32'hF0F0_1234; a_req_b = 32'h0FF0_FFFF; a_req_valid = 1'b1; a_rsp_ready = 1'b1;
    tick();
    a_req_valid = 1'b0; a_req_a = 32'hDEAD_BEEF; a_req_b = 32'hFFFF_FFFF;
    chk("t1_arr_a", a_arr_a, 32'hF0F0_1234);
    chk("t1_arr_b", a_arr_b, 32'h0FF0_FFFF);
    chk("t1_req_ready_busy", {31'b0, a_req_ready}, 32'h0);
    chk("t1_rsp_valid_early", {31'b0, a_rsp_valid}, 32'h0);
    tick();
    chk("t1_rsp_valid", {31'b0, a_rsp_valid}, 32'h1);
    chk("t1_rsp_data", a_rsp_data, 32'h00F0_1234);
    chk("t1_rsp_zero", {31'b0, a_rsp_zero}, 32'h0);
    tick();
    chk("t1_rsp_valid_drop", {31'b0, a_rsp_valid}, 32'h0);
    chk("t1_txn", {16'b0, a_txn}, 32'h1);
    chk("t1_req_ready_back", {31'b0, a_req_ready}, 32'h1);
    chk("t1_data_retained", a_rsp_data, 32'h00F0_1234);
    chk("t1_arr_a_retained", a_arr_a, 32'hF0F0_1234);

    // Zero result.
    a_req_a = 32'hAAAA_AAAA; a_req_b = 32'h5555_5555; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    tick();
    chk("t2_rsp_valid", {31'b0, a_rsp_valid}, 32'h1);
    chk("t2_rsp_data", a_rsp_data, 32'h0);
    chk("t2_rsp_zero", {31'b0, a_rsp_zero}, 32'h1);
`ifdef ALU_LOGIC_PARITY_EN
    chk("t2_parity", {31'b0, a_rsp_parity}, 32'h0);
`endif
    tick();
    chk("t2_txn", {16'b0, a_txn}, 32'h2);

    // Back-pressure with a second request waiting.
    a_rsp_ready = 1'b0;
    a_req_a = 32'h1234_5678; a_req_b = 32'hFFFF_0000; a_req_valid = 1'b1;
    tick();
    a_req_a = 32'hFFFF_FFFF; a_req_b = 32'h0000_FFFF;
    tick();
    chk("t3_rsp_valid", {31'b0, a_rsp_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_bp_req_ready_%0d", i), {31'b0, a_req_ready}, 32'h0);
      chk($sformatf("t3_bp_rsp_valid_%0d", i), {31'b0, a_rsp_valid}, 32'h1);
      chk($sformatf("t3_bp_rsp_data_%0d", i), a_rsp_data, 32'h1234_0000);
      chk($sformatf("t3_bp_arr_a_%0d", i), a_arr_a, 32'h1234_5678);
    end
    a_rsp_ready = 1'b1;
    tick();
    chk("t3_hs_rsp_valid", {31'b0, a_rsp_valid}, 32'h0);
    chk("t3_hs_req_ready", {31'b0, a_req_ready}, 32'h1);
    chk("t3_hs_txn", {16'b0, a_txn}, 32'h3);
    chk("t3_hs_arr_a_old", a_arr_a, 32'h1234_5678);
    tick();
    a_req_valid = 1'b0;
    chk("t3_second_arr_a", a_arr_a, 32'hFFFF_FFFF);
    chk("t3_second_arr_b", a_arr_b, 32'h0000_FFFF);
    tick();
    chk("t3_second_data", a_rsp_data, 32'h0000_FFFF);
    tick();
    chk("t3_second_txn", {16'b0, a_txn}, 32'h4);

    // Three-cycle settle: only the final settle edge samples arr_s.
    b_ovr = 1'b1; b_ovr_val = 32'h1111_1111; b_rsp_ready = 1'b0;
    b_req_a = 32'hFF00_FF00; b_req_b = 32'h0F0F_0F0F; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
    chk("s3_arr_a", b_arr_a, 32'hFF00_FF00);
    tick();
    chk("s3_valid_k1", {31'b0, b_rsp_valid}, 32'h0);
    b_ovr_val = 32'h2222_2222;
    tick();
    chk("s3_valid_k2", {31'b0, b_rsp_valid}, 32'h0);
    b_ovr_val = 32'hCAFE_F00D;
    tick();
    chk("s3_valid_k3", {31'b0, b_rsp_valid}, 32'h1);
    chk("s3_data", b_rsp_data, 32'hCAFE_F00D);
    b_ovr_val = 32'h0;
    tick();
    chk("s3_data_held", b_rsp_data, 32'hCAFE_F00D);
    chk("s3_zero_held", {31'b0, b_rsp_zero}, 32'h0);
    b_rsp_ready = 1'b1;
    tick();
    chk("s3_txn", {28'b0, b_txn}, 32'h1);
    b_ovr = 1'b0;

    // Async reset in the middle of SETTLE.
    b_req_a = 32'h0F0F_0F0F; b_req_b = 32'hFFFF_FFFF; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
    tick();
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("ar_arr_a", b_arr_a, 32'h0);
    chk("ar_rsp_data", b_rsp_data, 32'h0);
    chk("ar_rsp_valid", {31'b0, b_rsp_valid}, 32'h0);
    chk("ar_txn", {28'b0, b_txn}, 32'h0);
    tick();
    b_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ar_no_rsp_%0d", i), {31'b0, b_rsp_valid}, 32'h0);
    end
    chk("ar_req_ready", {31'b0, b_req_ready}, 32'h1);
    b_req_a = 32'h8000_0001; b_req_b = 32'hF000_000F; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
    tick(); tick(); tick();
    chk("ar_after_valid", {31'b0, b_rsp_valid}, 32'h1);
    chk("ar_after_data", b_rsp_data, 32'h8000_0001);
    tick();
    chk("ar_after_txn", {28'b0, b_txn}, 32'h1);

    // Sixteen more transactions wrap the 4-bit counter to 1; array forced to 7.
    b_ovr = 1'b1; b_ovr_val = 32'h0000_0007;
    for (int i = 0; i < 16; i++) begin
      b_req_a = 32'(i); b_req_b = 32'hFFFF_FFFF; b_req_valid = 1'b1;
      tick();
      b_req_valid = 1'b0;
      tick(); tick(); tick();
      if (i == 15) begin
        chk("wr_data", b_rsp_data, 32'h0000_0007);
`ifdef ALU_LOGIC_PARITY_EN
        chk("wr_parity", {31'b0, b_rsp_parity}, 32'h1);
`endif
      end
      tick();
    end
    chk("wr_txn", {28'b0, b_txn}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
